compress_scheduler: RTL and testbench

Output requantization scheduler for the accumulator array. It accepts one block of LANES signed accumulator sums over a valid/ready handshake and serialises the lanes through a single shared saturate-and-shift stage, one lane per cycle. It packs the resulting int8 values four per 32-bit word and emits the words over a valid/ready output handshake toward the activation buffer. It also keeps a running count of saturated lanes for quantization-scale tuning.

---
 rtl/compress_scheduler.sv | 105 ++++++++++
 tb/tb_compress_scheduler.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/compress_scheduler.sv
// Output requantization scheduler: captures one block of signed accumulator sums,
// saturate-shifts one lane per cycle to int8, and streams packed 32-bit words.
module compress_scheduler #(
  parameter int SUM_WIDTH = 20,
  parameter int LANES     = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [LANES*SUM_WIDTH-1:0]   in_sums,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [31:0]                  out_data,
  output logic                         out_last,
  output logic                         busy,
  input  logic                         sat_clr,
  output logic [15:0]                  sat_count
);

  localparam int LW = $clog2(LANES);
  localparam int HW = SUM_WIDTH - 8;

  typedef enum logic [1:0] {IDLE, PACK, SEND} state_t;

  state_t                       state, state_nxt;
  logic [LW-1:0]                lane;
  logic [LANES*SUM_WIDTH-1:0]   blk_buf;
  logic [HW-1:0]                lane_hi;
  logic                         lane_sat;
  logic [7:0]                   lane_byte;
  logic                         accept;

  assign accept = (state == IDLE) && in_valid;

  // Shared compress stage: the lane counter selects which buffered sum feeds it.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    lane_hi   = blk_buf[lane*SUM_WIDTH + 8 +: HW];
    lane_sat  = !((&lane_hi[HW-1:7]) || !(|lane_hi[HW-1:7]));
    lane_byte = lane_hi[7:0];
    if (lane_sat)
      lane_byte = lane_hi[HW-1] ? 8'h80 : 8'h7F;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = PACK;
      end
      PACK: begin
        if (lane[1:0] == 2'd3) state_nxt = SEND;
      end
      SEND: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = out_last ? IDLE : PACK;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: the block buffer has no reset; it is always written on accept before it is read.
  always_ff @(posedge clk) begin
    if (accept) blk_buf <= in_sums;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane     <= '0;
      out_data <= '0;
      out_last <= 1'b0;
    end else begin
      if (accept) lane <= '0;
      if (state == PACK) begin
        out_data[8*lane[1:0] +: 8] <= lane_byte;
        lane                       <= lane + 1'b1;
        if (lane[1:0] == 2'd3) out_last <= (lane == LW'(LANES-1));
      end
      if ((state == SEND) && out_ready) out_last <= 1'b0;
    end
  end

  // Clear takes priority, so an increment in the clear cycle is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sat_count <= '0;
    else if (sat_clr)
      sat_count <= '0;
    else if ((state == PACK) && lane_sat && (sat_count != 16'hFFFF))
      sat_count <= sat_count + 16'd1;
  end

endmodule

// File: tb/tb_compress_scheduler.sv
// Self-checking bench for compress_scheduler: directed and random blocks checked
// against an arithmetic model of the clamp-and-pack rule.
module tb_compress_scheduler;

  localparam int SW    = 20;
  localparam int LANES = 8;
  localparam int NW    = LANES / 4;
  localparam int BW    = LANES * SW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [BW-1:0] in_sums = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [31:0]   out_data;
  logic          out_last;
  logic          busy;
  logic          sat_clr = 1'b0;
  logic [15:0]   sat_count;

  int n_checks  = 0;
  int n_pass    = 0;
  int model_sat = 0;

  compress_scheduler #(.SUM_WIDTH(SW), .LANES(LANES)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sums(in_sums),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .sat_clr(sat_clr), .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Reference: floor(sum / 256), clamped to int8.
  function automatic int lane_q(input logic [SW-1:0] s);
    logic signed [SW-1:0] ss;
    ss = s;
    return int'(ss) >>> 8;
  endfunction

  function automatic logic [7:0] ref_byte(input logic [SW-1:0] s);
    int q;
    q = lane_q(s);
    if (q > 127)  return 8'h7F;
    if (q < -128) return 8'h80;
    return 8'(q);
  endfunction

  function automatic logic [31:0] ref_word(input logic [BW-1:0] blk, input int w);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = ref_byte(blk[(4*w+k)*SW +: SW]);
    return r;
  endfunction

  function automatic int ref_nsat(input logic [BW-1:0] blk);
    int n = 0;
    for (int i = 0; i < LANES; i++) begin
      int q;
      q = lane_q(blk[i*SW +: SW]);
      if (q > 127 || q < -128) n++;
    end
    return n;
  endfunction

  function automatic int sat_add(input int a, input int n);
    return (a + n > 65535) ? 65535 : a + n;
  endfunction

  function automatic logic [BW-1:0] rand_block();
    logic [BW-1:0] b;
    for (int i = 0; i < LANES; i++) begin
      if ($urandom_range(0, 1) == 0) b[i*SW +: SW] = SW'($urandom);
      else                           b[i*SW +: SW] = SW'(int'($urandom_range(0, 65535)) - 32768);
    end
    return b;
  endfunction

  task automatic wait_valid(input string tag);
    int cyc = 0;
    while (!out_valid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, " out_valid"}, 32'(out_valid), 32'd1);
  endtask

  task automatic accept(input logic [BW-1:0] blk);
    int cyc = 0;
    while (!in_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("in_ready before accept", 32'(in_ready), 32'd1);
    in_sums  = blk;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
    in_sums   = {$urandom, $urandom, $urandom, $urandom, $urandom};
    model_sat = sat_add(model_sat, ref_nsat(blk));
  endtask

  task automatic expect_word(input string tag, input logic [31:0] exp, input logic exp_last,
                             input int stall);
    out_ready = (stall == 0);
    wait_valid(tag);
    check({tag, " data"}, out_data, exp);
    check({tag, " last"}, 32'(out_last), 32'(exp_last));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check({tag, " held valid"}, 32'(out_valid), 32'd1);
      check({tag, " held data"}, out_data, exp);
      check({tag, " held in_ready"}, 32'(in_ready), 32'd0);
      check({tag, " held busy"}, 32'(busy), 32'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic expect_block(input string tag, input logic [BW-1:0] blk, input int max_stall);
    for (int w = 0; w < NW; w++)
      expect_word($sformatf("%s w%0d", tag, w), ref_word(blk, w), (w == NW-1),
                  int'($urandom_range(0, max_stall)));
    check({tag, " sat_count"}, 32'(sat_count), 32'(model_sat));
  endtask

  initial begin
    logic [BW-1:0] blk, blk_b;
    int cyc;

    repeat (2) @(negedge clk);
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset busy", 32'(busy), 32'd0);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_data", out_data, 32'd0);
    check("reset out_last", 32'(out_last), 32'd0);
    check("reset sat_count", 32'(sat_count), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic packing with lane i = i<<8, plus accept-to-valid latency.
    for (int i = 0; i < LANES; i++) blk[i*SW +: SW] = SW'(i << 8);
    accept(blk);
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("first word latency", 32'(cyc), 32'd4);
    expect_block("basic", blk, 0);

    // Saturation and clamp boundaries.
    blk = {20'hFFF00, 20'h000FF, 20'hF8000, 20'hF7FFF, 20'h08000, 20'h07F00, 20'h80000, 20'h7FFFF};
    accept(blk);
    expect_block("sat", blk, 0);

    // Backpressure for 10 cycles on the first word.
    blk = rand_block();
    accept(blk);
    expect_word("bp w0", ref_word(blk, 0), 1'b0, 10);
    expect_word("bp w1", ref_word(blk, 1), 1'b1, 0);
    check("bp sat_count", 32'(sat_count), 32'(model_sat));

    // Random blocks with random output stalls.
    for (int b = 0; b < 6; b++) begin
      blk = rand_block();
      accept(blk);
      expect_block($sformatf("rnd%0d", b), blk, 3);
    end

    // Back-to-back blocks with in_valid held high.
    blk   = rand_block();
    blk_b = rand_block();
    in_sums  = blk;
    in_valid = 1'b1;
    @(negedge clk);
    check("b2b A accepted", 32'(busy), 32'd1);
    in_sums   = blk_b;
    model_sat = sat_add(model_sat, ref_nsat(blk));
    expect_word("b2b A w0", ref_word(blk, 0), 1'b0, 0);
    expect_word("b2b A w1", ref_word(blk, 1), 1'b1, 0);
    check("b2b idle in_ready", 32'(in_ready), 32'd1);
    check("b2b idle busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("b2b B accepted in_ready", 32'(in_ready), 32'd0);
    check("b2b B accepted busy", 32'(busy), 32'd1);
    in_valid  = 1'b0;
    model_sat = sat_add(model_sat, ref_nsat(blk_b));
    expect_block("b2b B", blk_b, 0);

    // Clear in the same cycle as a saturating lane wins.
    for (int i = 0; i < LANES; i++) blk[i*SW +: SW] = SW'(i << 8);
    blk[0 +: SW] = 20'h7FFFF;
    accept(blk);
    sat_clr = 1'b1;
    @(negedge clk);
    sat_clr   = 1'b0;
    model_sat = 0;
    check("clear beats increment", 32'(sat_count), 32'd0);
    expect_block("clr", blk, 0);

    // Preload near the top and check the count holds at 0xFFFF.
    force dut.sat_count = 16'hFFFE;
    #1;
    release dut.sat_count;
    check("preload sat_count", 32'(sat_count), 32'h0000FFFE);
    model_sat = 65534;
    for (int i = 0; i < LANES; i++) blk[i*SW +: SW] = SW'(i << 8);
    blk[0*SW +: SW] = 20'h7FFFF;
    blk[1*SW +: SW] = 20'h80000;
    blk[2*SW +: SW] = 20'h08000;
    accept(blk);
    expect_block("hold", blk, 0);

    // Asynchronous reset during PACK of word 0.
    blk = rand_block();
    blk[0 +: SW] = 20'h01200;
    accept(blk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset out_valid", 32'(out_valid), 32'd0);
    check("midreset in_ready", 32'(in_ready), 32'd1);
    check("midreset busy", 32'(busy), 32'd0);
    check("midreset sat_count", 32'(sat_count), 32'd0);
    check("midreset out_data", out_data, 32'd0);
    check("midreset out_last", 32'(out_last), 32'd0);
    model_sat = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    blk = rand_block();
    accept(blk);
    expect_block("post reset", blk, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
